// File: rtl/mimc_pkg.sv
// Shared MiMC/BN254 definitions: field modulus, Barrett constant, round-constant step,
// hash FSM states and a single-subtract modular adder.
package mimc_pkg;

  localparam int N      = 254;
  localparam int ROUNDS = 91;

  localparam logic [N-1:0] P_BN254    = 254'h3064_4e72_e131_a029_b850_45b6_8181_585d_2833_e848_79b9_7091_43e1_f593_f000_0001;
  localparam logic [N-1:0] IV_DEFAULT = '0;

  // Round constants form an arithmetic progression: c_i = i * RC_STEP mod P.
  localparam logic [N-1:0] RC_STEP = 254'h0b3d_6a8f_1c47_e925_5f0a_7d31_c86e_24b9_a153_07ce_6d92_f48b_3e71_c0a5_9d26_8b4f;

  localparam logic [2*N:0] MU_NUM = {1'b1, {(2*N){1'b0}}};
  localparam logic [N:0]   MU     = (N+1)'(MU_NUM / {{(N+1){1'b0}}, P_BN254});

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_FOLD,
    S_OUT
  } state_t;

  // Both operands must already be reduced below P.
  function automatic logic [N-1:0] mod_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P_BN254}) s = s - {1'b0, P_BN254};
    return N'(s);
  endfunction

endpackage

// File: rtl/mimc_cipher.sv
// MiMC-7 block cipher over BN254 r, one full round (x + k + c_i)^7 per clock, ROUNDS rounds.
// en starts a run (inputs sampled); done pulses one cycle with ct valid and held afterwards.
module mimc_cipher import mimc_pkg::*; #(
  parameter string GALOIS_MULT_METHOD       = "barrett",
  parameter string GALOIS_POW_7_METHOD      = "parallel",
  parameter string MIMC_CIPHER_ROUND_METHOD = "v1"
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] msg,
  input  logic [N-1:0] key,
  output logic [N-1:0] ct,
  output logic         done
);

  localparam bit USE_BARRETT   = (GALOIS_MULT_METHOD == "barrett");
  localparam bit POW_PARALLEL  = (GALOIS_POW_7_METHOD == "parallel");
  localparam bit ADD_FINAL_KEY = (MIMC_CIPHER_ROUND_METHOD == "v1");

  // Barrett with k = 254: remainder lands below 3P, so at most two corrective subtracts.
  function automatic logic [N-1:0] mul_mod(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] prod;
    logic [2*N+1:0] q2;
    logic [2*N+1:0] qp;
    logic [N:0]     q3;
    logic [N+1:0]   r;
    prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    if (USE_BARRETT) begin
      q2 = {{(N+1){1'b0}}, (N+1)'(prod >> (N-1))} * {{(N+1){1'b0}}, MU};
      q3 = (N+1)'(q2 >> (N+1));
      qp = {{(N+1){1'b0}}, q3} * {{(N+2){1'b0}}, P_BN254};
      r  = (N+2)'(prod) - (N+2)'(qp);
      if (r >= {2'b00, P_BN254}) r = r - {2'b00, P_BN254};
      if (r >= {2'b00, P_BN254}) r = r - {2'b00, P_BN254};
      return N'(r);
    end else begin
      return N'(prod % {{N{1'b0}}, P_BN254});
    end
  endfunction

  logic [N-1:0] x;
  logic [N-1:0] k;
  logic [N-1:0] c;
  logic [6:0]   rnd;
  logic         run;

  logic [N-1:0] t;
  logic [N-1:0] x2;
  logic [N-1:0] x3;
  logic [N-1:0] x4;
  logic [N-1:0] x6;
  logic [N-1:0] x7;

  always_comb begin
    t  = mod_add(mod_add(x, k), c);
    x2 = mul_mod(t, t);
    x4 = mul_mod(x2, x2);
    x3 = '0;
    x6 = '0;
    x7 = '0;
    if (POW_PARALLEL) begin
      x3 = mul_mod(x2, t);
      x7 = mul_mod(x4, x3);
    end else begin
      x6 = mul_mod(x4, x2);
      x7 = mul_mod(x6, t);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x    <= '0;
      k    <= '0;
      c    <= '0;
      rnd  <= '0;
      run  <= 1'b0;
      ct   <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (en) begin
        x   <= msg;
        k   <= key;
        c   <= '0;
        rnd <= '0;
        run <= 1'b1;
      end else if (run) begin
        x   <= x7;
        c   <= mod_add(c, RC_STEP);
        rnd <= rnd + 7'd1;
        if (rnd == 7'(ROUNDS - 1)) begin
          run  <= 1'b0;
          done <= 1'b1;
          ct   <= ADD_FINAL_KEY ? mod_add(x7, k) : x7;
        end
      end
    end
  end

endmodule

// File: rtl/mimc_hash_stream.sv
// Streaming MiMC Miyaguchi-Preneel hash (h' = E_h(m) + h + m mod P), one digest per in_last-terminated message.
// Optional input range check under `MIMC_HASH_RANGE_CHECK_EN (adds out_err).
module mimc_hash_stream import mimc_pkg::*; #(
  parameter int                N_BITS                   = 254,
  parameter logic [N_BITS-1:0] P                        = P_BN254,
  parameter logic [N_BITS-1:0] IV                       = IV_DEFAULT,
  parameter int                CNT_W                    = 16,
  parameter string             GALOIS_MULT_METHOD       = "barrett",
  parameter string             GALOIS_POW_7_METHOD      = "parallel",
  parameter string             MIMC_CIPHER_ROUND_METHOD = "v1"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] out_hash,
  output logic [CNT_W-1:0]  out_count,
`ifdef MIMC_HASH_RANGE_CHECK_EN
  output logic              out_err,
`endif
  output logic              busy
);

  state_t state;
  state_t state_nxt;

  logic [N_BITS-1:0] h;
  logic [N_BITS-1:0] m;
  logic [N_BITS-1:0] e;
  logic              last;
  logic [CNT_W-1:0]  count;
  logic              cipher_en;
  logic              cipher_done;
  logic [N_BITS-1:0] cipher_ct;
  logic [N_BITS:0]   s1_raw;
  logic [N_BITS-1:0] s1;
  logic [N_BITS:0]   s2_raw;
  logic [N_BITS-1:0] fold_sum;
`ifdef MIMC_HASH_RANGE_CHECK_EN
  logic              err;
`endif

  mimc_cipher #(
    .GALOIS_MULT_METHOD      (GALOIS_MULT_METHOD),
    .GALOIS_POW_7_METHOD     (GALOIS_POW_7_METHOD),
    .MIMC_CIPHER_ROUND_METHOD(MIMC_CIPHER_ROUND_METHOD)
  ) u_cipher (
    .clk (clk),
    .rst (rst),
    .en  (cipher_en),
    .msg (m),
    .key (h),
    .ct  (cipher_ct),
    .done(cipher_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cipher_en = 1'b0;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_START;
      S_START: begin
        cipher_en = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT:  if (cipher_done) state_nxt = S_FOLD;
      S_FOLD:  state_nxt = last ? S_OUT : S_IDLE;
      S_OUT:   if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    s1_raw   = {1'b0, h} + {1'b0, m};
    s1       = N_BITS'((s1_raw >= {1'b0, P}) ? s1_raw - {1'b0, P} : s1_raw);
    s2_raw   = {1'b0, s1} + {1'b0, e};
    fold_sum = N_BITS'((s2_raw >= {1'b0, P}) ? s2_raw - {1'b0, P} : s2_raw);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h     <= IV;
      m     <= '0;
      e     <= '0;
      last  <= 1'b0;
      count <= '0;
`ifdef MIMC_HASH_RANGE_CHECK_EN
      err   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          last <= in_last;
`ifdef MIMC_HASH_RANGE_CHECK_EN
          // Out-of-field elements are absorbed as zero and flagged for the whole message.
          if (in_data >= P) begin
            m   <= '0;
            err <= 1'b1;
          end else begin
            m   <= in_data;
          end
`else
          m <= in_data;
`endif
        end
        S_WAIT: if (cipher_done) e <= cipher_ct;
        S_FOLD: begin
          h <= fold_sum;
          if (count != '1) count <= count + CNT_W'(1);
        end
        S_OUT: if (out_ready) begin
          h     <= IV;
          count <= '0;
`ifdef MIMC_HASH_RANGE_CHECK_EN
          err   <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_OUT);
  assign busy      = (state != S_IDLE);
  assign out_hash  = out_valid ? h : '0;
  assign out_count = out_valid ? count : '0;
`ifdef MIMC_HASH_RANGE_CHECK_EN
  assign out_err   = out_valid & err;
`endif

endmodule
